uart_host_ctrl: RTL and testbench
=================================

UART_HOST_CTRL -- requirements
Module: uart_host_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, idle cycles after each UART access before status is re-sampled; legal range 1..15.
REQ-002 SHALL have parameter DROP_PARITY_ERR, default 1: 1 = discard bytes read with PARITY_ERR high; 0 = forward them.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: CLK  in  1  system clock; RESET_N  in  1  asynchronous active-low reset.
REQ-004 tx_data  in  8  byte to transmit.
REQ-005 tx_valid  in  1  tx_data valid.
REQ-006 tx_ready  out  1  byte accepted when tx_valid and tx_ready are both high.
REQ-007 rx_data  out  8  received byte.
REQ-008 rx_valid  out  1  rx_data valid.
REQ-009 rx_ready  in  1  consumer accepts rx_data.
REQ-010 CSN, WEN, OEN  out  1 each  active-low UART chip select, write strobe and read strobe.
REQ-011 UDATA_W  out  8  write data to UART DATA_IN.
REQ-012 UDATA_R  in  8  UART DATA_OUT (combinational).
REQ-013 TXRDY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW  in  1 each  UART status.
REQ-014 err_cnt  out  24  {overflow[7:0], framing[7:0], parity[7:0]} error counts (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, WRITE, READ, SETTLE.
REQ-016 IDLE: rx_pend = RXRDY & !rx_valid; tx_pend = tx_valid & TXRDY; if exactly one is pending, go to the matching state.
REQ-017 If both are pending, SHALL grant round-robin via a last_grant bit; the first conflict after reset SHALL grant READ.
REQ-018 WRITE (1 cycle): CSN=0, WEN=0, UDATA_W=tx_data, tx_ready=1; then SETTLE.
REQ-019 tx_ready SHALL be high only in WRITE; tx_data SHALL be sampled only in that cycle.
REQ-020 READ (1 cycle): CSN=0, OEN=0; UDATA_R and PARITY_ERR captured at the clock edge ending READ; then SETTLE.
REQ-021 After READ, rx_valid SHALL rise on the next cycle with the captured byte, unless PARITY_ERR was high and DROP_PARITY_ERR=1.
REQ-022 rx_valid/rx_data SHALL hold until rx_ready; a 1-entry buffer; no READ is issued while rx_valid is high.
REQ-023 SETTLE: SHALL count SETTLE_CYCLES cycles with all strobes high, then return to IDLE; status inputs SHALL be ignored during SETTLE.
REQ-024 Outside WRITE/READ: CSN=WEN=OEN=1; UDATA_W SHALL hold its last value.
REQ-025 tx_valid dropping before grant SHALL cancel the pending write with no UART access.
REQ-026 Error counters: increment on a rising edge of the respective input, detected against a registered copy, saturating at 8'hFF.
REQ-027 A parity-error byte SHALL count in the parity counter even when it is dropped.

Reset
REQ-028 On RESET_N low, asynchronously: state=IDLE, CSN=WEN=OEN=1, tx_ready=0, rx_valid=0, rx_data=0, UDATA_W=0, err_cnt=0, last_grant=TX, settle counter=0, edge registers=0.
REQ-029 Reset mid-access SHALL abort immediately; any buffered rx byte SHALL be lost.

Configuration
REQ-030 Macro UART_HOST_ERR_CNT_EN: defined -> counters and edge detectors per REQ-026/027; undefined -> no counter logic, err_cnt tied to 24'h0, dropping behaviour unchanged.

Verification
REQ-031 TXRDY=1, tx_valid with 8'hA5 -> one cycle CSN=0/WEN=0/UDATA_W=A5, tx_ready pulse, then 2 idle cycles (SETTLE_CYCLES=2).
REQ-032 RXRDY=1, UDATA_R=8'h3C, rx_ready=0 -> single READ, rx_valid=1 with rx_data=3C held; no second READ until rx_ready=1.
REQ-033 RXRDY and tx_valid both held continuously -> accesses alternate READ, WRITE, READ, ..., first READ.
REQ-034 Read with PARITY_ERR=1, DROP_PARITY_ERR=1 -> rx_valid stays 0; parity count increments 0->1 with macro defined, stays 0 without it.
REQ-035 300 FRAMING_ERR pulses -> framing count saturates at 8'hFF; RESET_N low mid-READ -> all strobes high in the same cycle and err_cnt=0.

Source files
------------

// File: rtl/uart_host_ctrl.sv
// Bridges a valid/ready byte stream onto a strobed UART register port with round-robin arbitration.
// Optional saturating error counters are built only when UART_HOST_ERR_CNT_EN is defined.
module uart_host_ctrl #(
   parameter int SETTLE_CYCLES   = 2,
   parameter int DROP_PARITY_ERR = 1
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        CSN,
   output logic        WEN,
   output logic        OEN,
   output logic [7:0]  UDATA_W,
   input  logic [7:0]  UDATA_R,
   input  logic        TXRDY,
   input  logic        RXRDY,
   input  logic        PARITY_ERR,
   input  logic        FRAMING_ERR,
   input  logic        OVERFLOW,
   output logic [23:0] err_cnt
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, SETTLE} state_t;

   localparam logic GRANT_RX = 1'b0;
   localparam logic GRANT_TX = 1'b1;
   localparam logic DROP     = (DROP_PARITY_ERR != 0);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic       last_grant;
   logic       last_grant_nxt;
   logic [3:0] settle_cnt;
   logic [7:0] wdata_q;
   logic       rx_pend;
   logic       tx_pend;

   assign rx_pend = RXRDY & ~rx_valid;
   assign tx_pend = tx_valid & TXRDY;

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      CSN            = 1'b1;
      WEN            = 1'b1;
      OEN            = 1'b1;
      tx_ready       = 1'b0;
      case (state)
         IDLE: begin
            if (rx_pend && tx_pend) begin
               if (last_grant == GRANT_TX) begin
                  state_nxt      = READ;
                  last_grant_nxt = GRANT_RX;
               end else begin
                  state_nxt      = WRITE;
                  last_grant_nxt = GRANT_TX;
               end
            end else if (rx_pend) begin
               state_nxt      = READ;
               last_grant_nxt = GRANT_RX;
            end else if (tx_pend) begin
               state_nxt      = WRITE;
               last_grant_nxt = GRANT_TX;
            end
         end
         WRITE: begin
            CSN       = 1'b0;
            WEN       = 1'b0;
            tx_ready  = 1'b1;
            state_nxt = SETTLE;
         end
         READ: begin
            CSN       = 1'b0;
            OEN       = 1'b0;
            state_nxt = SETTLE;
         end
         SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The write bus shows live tx_data during WRITE and otherwise holds the last byte written.
   assign UDATA_W = (state == WRITE) ? tx_data : wdata_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= IDLE;
         last_grant <= GRANT_TX;
         settle_cnt <= 4'd0;
         wdata_q    <= 8'h00;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         if (state == SETTLE && state_nxt == SETTLE) begin
            settle_cnt <= settle_cnt + 4'd1;
         end else begin
            settle_cnt <= 4'd0;
         end
         if (state == WRITE) begin
            wdata_q <= tx_data;
         end
      end
   end

   // Single-entry receive buffer; a full buffer blocks further reads via rx_pend.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
      end else if (state == READ) begin
         rx_data  <= UDATA_R;
         rx_valid <= ~(PARITY_ERR & DROP);
      end else if (rx_valid && rx_ready) begin
         rx_valid <= 1'b0;
      end
   end

`ifdef UART_HOST_ERR_CNT_EN
   logic [2:0] status_now;
   logic [2:0] status_q;
   logic [7:0] cnt_q [3];

   assign status_now = {OVERFLOW, FRAMING_ERR, PARITY_ERR};

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         status_q <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= 8'h00;
         end
      end else begin
         status_q <= status_now;
         for (int i = 0; i < 3; i++) begin
            if (status_now[i] && !status_q[i] && cnt_q[i] != 8'hFF) begin
               cnt_q[i] <= cnt_q[i] + 8'd1;
            end
         end
      end
   end

   assign err_cnt = {cnt_q[2], cnt_q[1], cnt_q[0]};
`else
   logic unused_status;
   assign unused_status = FRAMING_ERR ^ OVERFLOW;
   assign err_cnt       = 24'h0;
`endif

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Self-checking bench for uart_host_ctrl: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_host_ctrl;

   localparam int SETTLE = 2;
   localparam bit DROP   = 1'b1;
`ifdef UART_HOST_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   localparam int ACC_NONE = 0;
   localparam int ACC_W    = 1;
   localparam int ACC_R    = 2;

   logic        CLK;
   logic        RESET_N;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        CSN;
   logic        WEN;
   logic        OEN;
   logic [7:0]  UDATA_W;
   logic [7:0]  UDATA_R;
   logic        TXRDY;
   logic        RXRDY;
   logic        PARITY_ERR;
   logic        FRAMING_ERR;
   logic        OVERFLOW;
   logic [23:0] err_cnt;

   uart_host_ctrl #(.SETTLE_CYCLES(SETTLE), .DROP_PARITY_ERR(1)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .CSN(CSN), .WEN(WEN), .OEN(OEN),
      .UDATA_W(UDATA_W), .UDATA_R(UDATA_R),
      .TXRDY(TXRDY), .RXRDY(RXRDY),
      .PARITY_ERR(PARITY_ERR), .FRAMING_ERR(FRAMING_ERR), .OVERFLOW(OVERFLOW),
      .err_cnt(err_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input logic tv, input logic [7:0] td, input logic trdy,
                                 input logic rrdy, input logic [7:0] ur, input logic rr);
      tx_valid = tv;
      tx_data  = td;
      TXRDY    = trdy;
      RXRDY    = rrdy;
      UDATA_R  = ur;
      rx_ready = rr;
   endtask

   // Reference model: which access occupies the current cycle, how many quiet cycles remain, whose turn it is.
   int         m_access;
   int         m_quiet;
   bit         m_read_turn;
   bit         m_full;
   logic [7:0] m_byte;
   logic [7:0] m_last_w;
   int         m_cnt [3];
   bit         m_prev [3];
   int         m_nxt;
   bit         m_rxp;
   bit         m_txp;
   logic [2:0] m_status;

   initial begin
      forever begin
         @(posedge CLK or negedge RESET_N);
         if (!RESET_N) begin
            m_access    = ACC_NONE;
            m_quiet     = 0;
            m_read_turn = 1'b1;
            m_full      = 1'b0;
            m_byte      = 8'h00;
            m_last_w    = 8'h00;
            for (int i = 0; i < 3; i++) begin
               m_cnt[i]  = 0;
               m_prev[i] = 1'b0;
            end
         end else begin
            m_nxt = ACC_NONE;
            if (m_access != ACC_NONE) begin
               m_quiet = SETTLE;
            end else if (m_quiet > 0) begin
               m_quiet = m_quiet - 1;
            end else begin
               m_rxp = RXRDY && !m_full;
               m_txp = tx_valid && TXRDY;
               if (m_rxp && m_txp) m_nxt = m_read_turn ? ACC_R : ACC_W;
               else if (m_rxp)     m_nxt = ACC_R;
               else if (m_txp)     m_nxt = ACC_W;
               if (m_nxt != ACC_NONE) m_read_turn = (m_nxt == ACC_W);
            end
            if (m_access == ACC_R) begin
               m_full = !(PARITY_ERR && DROP);
               m_byte = UDATA_R;
            end else if (m_full && rx_ready) begin
               m_full = 1'b0;
            end
            if (m_access == ACC_W) m_last_w = tx_data;
            m_status = {OVERFLOW, FRAMING_ERR, PARITY_ERR};
            for (int i = 0; i < 3; i++) begin
               if (m_status[i] && !m_prev[i] && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
               m_prev[i] = m_status[i];
            end
            m_access = m_nxt;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge CLK);
         check_output("csn", 32'(CSN), 32'(m_access == ACC_NONE));
         check_output("wen", 32'(WEN), 32'(m_access != ACC_W));
         check_output("oen", 32'(OEN), 32'(m_access != ACC_R));
         check_output("tx_ready", 32'(tx_ready), 32'(m_access == ACC_W));
         check_output("udata_w", 32'(UDATA_W), 32'((m_access == ACC_W) ? tx_data : m_last_w));
         check_output("rx_valid", 32'(rx_valid), 32'(m_full));
         if (m_full) check_output("rx_data", 32'(rx_data), 32'(m_byte));
         check_output("err_cnt", 32'(err_cnt),
                      CNT_EN ? 32'({8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])}) : 32'h0);
      end
   end

   task automatic wait_strobe(input bit rd, input string name);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge CLK);
         if (rd ? !OEN : !WEN) found = 1'b1;
      end
      check_output(name, 32'(found), 32'd1);
   endtask

   task automatic pulse_reset();
      @(posedge CLK); #1;
      RESET_N = 1'b0;
      @(posedge CLK); #1;
      RESET_N = 1'b1;
   endtask

   initial begin
      #500000;
      errors++;
      $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   int  n_reads;
   int  n_acc;
   bit  seq_rd [6];

   initial begin
      RESET_N     = 1'b0;
      PARITY_ERR  = 1'b0;
      FRAMING_ERR = 1'b0;
      OVERFLOW    = 1'b0;
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_output("rst_csn", 32'(CSN), 32'd1);
      check_output("rst_wen", 32'(WEN), 32'd1);
      check_output("rst_oen", 32'(OEN), 32'd1);
      check_output("rst_tx_ready", 32'(tx_ready), 32'd0);
      check_output("rst_rx_valid", 32'(rx_valid), 32'd0);
      check_output("rst_rx_data", 32'(rx_data), 32'd0);
      check_output("rst_udata_w", 32'(UDATA_W), 32'd0);
      check_output("rst_err_cnt", 32'(err_cnt), 32'd0);
      @(posedge CLK); #1;
      RESET_N = 1'b1;

      // Single write of A5 followed by two quiet cycles.
      apply_stimulus(1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
      wait_strobe(1'b0, "wr_seen");
      check_output("wr_csn", 32'(CSN), 32'd0);
      check_output("wr_tx_ready", 32'(tx_ready), 32'd1);
      check_output("wr_udata_w", 32'(UDATA_W), 32'hA5);
      @(posedge CLK); #1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      for (int i = 0; i < SETTLE; i++) begin
         @(negedge CLK);
         check_output("settle_csn", 32'(CSN), 32'd1);
         check_output("settle_tx_ready", 32'(tx_ready), 32'd0);
         check_output("settle_udata_w", 32'(UDATA_W), 32'hA5);
      end

      // Single read of 3C held in the buffer until the consumer accepts.
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0);
      n_reads = 0;
      repeat (16) begin
         @(negedge CLK);
         if (!OEN) n_reads++;
      end
      check_output("rd_count", 32'(n_reads), 32'd1);
      check_output("rd_valid", 32'(rx_valid), 32'd1);
      check_output("rd_data", 32'(rx_data), 32'h3C);
      @(posedge CLK); #1;
      RXRDY    = 1'b0;
      rx_ready = 1'b1;
      @(negedge CLK);
      check_output("rd_hold", 32'(rx_valid), 32'd1);
      @(negedge CLK);
      check_output("rd_consumed", 32'(rx_valid), 32'd0);

      // Continuous contention after reset alternates, starting with a read.
      apply_stimulus(1'b1, 8'h5A, 1'b1, 1'b1, 8'h77, 1'b1);
      pulse_reset();
      n_acc = 0;
      for (int i = 0; i < 60 && n_acc < 6; i++) begin
         @(negedge CLK);
         if (!OEN || !WEN) begin
            seq_rd[n_acc] = !OEN;
            n_acc++;
         end
      end
      check_output("rr_count", 32'(n_acc), 32'd6);
      for (int k = 0; k < 6; k++) begin
         if (k < n_acc) check_output($sformatf("rr_order%0d", k), 32'(seq_rd[k]), 32'((k % 2) == 0));
      end

      // Parity-error read is dropped but still counted.
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      pulse_reset();
      @(posedge CLK); #1;
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hE1, 1'b0);
      PARITY_ERR = 1'b1;
      wait_strobe(1'b1, "par_rd_seen");
      @(posedge CLK); #1;
      RXRDY      = 1'b0;
      PARITY_ERR = 1'b0;
      repeat (4) begin
         @(negedge CLK);
         check_output("par_dropped", 32'(rx_valid), 32'd0);
      end
      check_output("par_cnt", 32'(err_cnt[7:0]), CNT_EN ? 32'd1 : 32'd0);

      // Framing counter saturates after 300 pulses.
      repeat (300) begin
         @(posedge CLK); #1;
         FRAMING_ERR = 1'b1;
         @(posedge CLK); #1;
         FRAMING_ERR = 1'b0;
      end
      @(negedge CLK);
      check_output("frm_sat", 32'(err_cnt[15:8]), CNT_EN ? 32'hFF : 32'h0);
      check_output("frm_par_kept", 32'(err_cnt[7:0]), CNT_EN ? 32'd1 : 32'd0);
      check_output("frm_ovf_zero", 32'(err_cnt[23:16]), 32'd0);

      // Reset asserted in the middle of a read aborts the access immediately.
      @(posedge CLK); #1;
      RXRDY = 1'b1;
      wait_strobe(1'b1, "abort_rd_seen");
      #1;
      RESET_N = 1'b0;
      #1;
      check_output("abort_csn", 32'(CSN), 32'd1);
      check_output("abort_oen", 32'(OEN), 32'd1);
      check_output("abort_wen", 32'(WEN), 32'd1);
      check_output("abort_err_cnt", 32'(err_cnt), 32'd0);
      @(posedge CLK); #1;
      RXRDY   = 1'b0;
      RESET_N = 1'b1;
      @(negedge CLK);
      check_output("abort_rx_lost", 32'(rx_valid), 32'd0);

      // Randomized traffic, checked every cycle by the model.
      for (int c = 0; c < 3000; c++) begin
         @(posedge CLK); #1;
         tx_valid    = ($urandom_range(0, 2) != 0);
         tx_data     = 8'($urandom);
         TXRDY       = ($urandom_range(0, 9) < 7);
         RXRDY       = ($urandom_range(0, 1) == 1);
         UDATA_R     = 8'($urandom);
         rx_ready    = ($urandom_range(0, 1) == 1);
         PARITY_ERR  = ($urandom_range(0, 9) == 0);
         FRAMING_ERR = ($urandom_range(0, 9) == 0);
         OVERFLOW    = ($urandom_range(0, 9) == 0);
         RESET_N     = (c != 1500);
      end
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      repeat (2) @(negedge CLK);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
